// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that steers the shared word mux: it grants one requester at a time
// for bursts of up to MAX_BURST words and acknowledges every word the consumer accepts.
module mux_rr_arbiter #(
  parameter int N_INPUTS  = 4,
  parameter int MAX_BURST = 4,
  localparam int SEL_W    = $clog2(N_INPUTS),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [N_INPUTS-1:0] req,
  output logic [N_INPUTS-1:0] ack,
  output logic [N_INPUTS-1:0] gnt,
  output logic [SEL_W-1:0]    selector,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                state_dbg
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]    selector_q, selector_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                xfer;
  logic                win_found;
  logic [SEL_W-1:0]    win_idx;
  logic [SEL_W:0]      cand_sum;
  logic [SEL_W-1:0]    cand;
  logic [SEL_W-1:0]    ptr_adv;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      selector_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      selector_q <= selector_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Rotating search: the first set request at or after ptr (mod N_INPUTS) wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      cand_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (cand_sum >= (SEL_W+1)'(N_INPUTS)) cand_sum = cand_sum - (SEL_W+1)'(N_INPUTS);
      cand = cand_sum[SEL_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_adv = (selector_q == SEL_W'(N_INPUTS - 1)) ? '0 : selector_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    selector_d = selector_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_GRANT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          selector_d       = win_idx;
          cnt_d            = '0;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_adv;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!req[selector_q]) begin
          // Withdrawn request: ends the burst early without an ack.
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_adv;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake: a word moves in any cycle where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and ack marks the owner of that word.
  always_comb begin
    out_valid = (state_q == S_GRANT) && req[selector_q];
    xfer      = out_valid && out_ready;
    ack       = xfer ? gnt_q : '0;
    busy      = (state_q == S_GRANT);
    state_dbg = state_q;
  end

  assign gnt      = gnt_q;
  assign selector = selector_q;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-input, 32-bit word multiplexer on the datapath.
- Up to N_INPUTS requesters compete for the mux. The block drives the mux selector and a valid/ready handshake toward the single downstream consumer.
- A granted requester may move a burst of up to MAX_BURST words before ownership rotates.
- Data does not pass through this block; it only steers the mux and acknowledges transfers.

Parameters:
- N_INPUTS, 4, number of requesters (2..4). Selector width is $clog2(N_INPUTS).
- MAX_BURST, 4, maximum words per grant (>=1). The burst counter is $clog2(MAX_BURST+1) bits wide.

Ports:
- clk, input, 1, rising-edge clock.
- clrn, input, 1, asynchronous active-low reset.
- req, input, N_INPUTS, per-requester level request. It is held high while the requester's word on its mux input is valid.
- ack, output, N_INPUTS, one-hot pulse. ack[i] is high in a cycle where requester i's word is transferred.
- gnt, output, N_INPUTS, one-hot registered grant. All zero when idle.
- selector, output, $clog2(N_INPUTS), registered mux select, equal to the owner index.
- out_valid, output, 1, word at mux output is valid.
- out_ready, input, 1, consumer accepts the word.
- busy, output, 1, high while in state GRANT.

Behaviour:
- Reset (clrn=0, async): state=IDLE, gnt=0, selector=0, rr pointer ptr=0, burst count cnt=0. out_valid=0, ack=0, busy=0.
- Only one clock domain exists. All state updates occur on the rising edge of clk.
- State IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ..., wrapping mod N_INPUTS.
  - Register gnt=onehot(winner), selector=winner, cnt=0, then go to GRANT.
  - If req==0, stay in IDLE.
  - Latency: req rising in cycle t gives gnt/selector/out_valid in cycle t+1.
- Output equations (combinational):
  - out_valid = (state==GRANT) & req[selector]. A withdrawn request never presents a word.
  - xfer = out_valid & out_ready.
  - ack = xfer ? gnt : 0.
- State GRANT, evaluated each edge:
  - xfer and cnt < MAX_BURST-1: stay in GRANT, cnt+1. Back-to-back words are allowed with no bubble.
  - xfer and cnt == MAX_BURST-1: burst ends. Go to IDLE, gnt=0, ptr=(selector+1) mod N_INPUTS, cnt=0.
  - no xfer and req[selector]==0: abort, which also covers a requester finishing a short burst. Go to IDLE, gnt=0, ptr=(selector+1) mod N_INPUTS. No ack is generated.
  - no xfer and req[selector]==1: hold all state. This is backpressure; there is no timeout.
- selector holds its last value in IDLE. Only gnt=0 marks idle.
- Requests from non-owners during GRANT are ignored until the return to IDLE. Exactly one idle cycle separates consecutive owners.
- A requester that still has req high after its burst re-competes. Because ptr has advanced past it, it has lowest priority.
- Fairness: with all requests continuously high and MAX_BURST=1, grants cycle 0,1,2,3,0,...
- req dropping in the same cycle as xfer: the transfer counts and ack fires. The next cycle aborts if req remains low.
- Reset asserted mid-burst: immediate return to the reset values, and any pending word is dropped. After clrn deasserts, arbitration restarts from ptr=0.

Test Plan:
- Single requester, MAX_BURST=4, out_ready=1, req=0100 held for 6 cycles:
  - Required: gnt=0100 and selector=2 one cycle after req.
  - 4 acks on consecutive cycles, then one IDLE cycle, then re-grant to 2 with ptr=3.
- All req=1111, out_ready=1, MAX_BURST=1:
  - Required grant order 0,1,2,3,0 with one idle cycle between grants.
  - Exactly one ack bit set per transfer.
- Backpressure, req=0001, out_ready=0 for 5 cycles then 1:
  - Required: gnt/selector/out_valid stable throughout, ack=0 until out_ready=1.
  - A single ack[0] then follows.
- Abort, req[1] granted, out_ready=0, then req[1] drops:
  - Required: out_valid=0 in the same cycle and IDLE next.
  - No ack; ptr=2, so a pending req[0]|req[3] is served as 3 before 0.
- Reset mid-burst:
  - Assert clrn=0 asynchronously between edges during the second word of owner 3.
  - Required: gnt, out_valid, ack=0 immediately; selector=0.
  - With req=1000 after release, owner 3 is granted again and cnt restarts at 0.
